piso_serializer: RTL
====================

# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, a runtime bit-order select, a shift-enable stall and frame delimiting. It takes WIDTH-bit words from an upstream producer and emits them one bit per enabled clock. It supports back-to-back frames with no idle bubble. It sits between a parallel datapath and any serial link or chained shift-register stage.

## Interface
- WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not to be overridden.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset. Assertion clears state immediately. Deassertion is synchronous to clk upstream.
- I  input  WIDTH  parallel word to load.
- load  input  1  upstream valid; I is stable while load=1.
- load_ready  output  1  block can accept a word this cycle.
- lsb_first  input  1  bit order, sampled only at load acceptance: 1 = I[0] first, 0 = I[WIDTH-1] first.
- shift_en  input  1  downstream advance; 0 stalls the current bit.
- serial_in  input  1  bit shifted into the vacated end of the register, for chaining.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a frame bit.
- last  output  1  serial_out is the final bit of the frame.
- busy  output  1  a frame is in progress (state SHIFT).

## Operation
- Load handshake: a load is accepted on a rising edge where load && load_ready.
- States:
  - IDLE: load_ready=1, serial_valid=0. An accepted load captures I, latches lsb_first into an internal order bit, sets cnt=WIDTH-1 and moves to SHIFT.
  - SHIFT: serial_valid=1. serial_out = shreg[0] if the order bit is 1, otherwise shreg[WIDTH-1].
- On each edge in SHIFT with shift_en=1 and cnt!=0:
  - LSB-first: shreg <= {serial_in, shreg[WIDTH-1:1]}.
  - MSB-first: shreg <= {shreg[WIDTH-2:0], serial_in}.
  - cnt decrements by 1.
- last = (state==SHIFT) && (cnt==0).
- load_ready = (state==IDLE) || (last && shift_en). This is combinational from state, cnt and shift_en.
- On the edge where last && shift_en:
  - If load=1, the new word is captured (back-to-back) and the block stays in SHIFT with cnt=WIDTH-1.
  - Otherwise the block returns to IDLE.
- shift_en=0 in SHIFT: shreg, cnt and all outputs hold. Any load presented is not accepted, because load_ready=0 unless in IDLE.
- shift_en is ignored in IDLE.
- In IDLE, shreg holds its last value and serial_out is a don't-care, gated to 0.
- busy = (state==SHIFT).
- A load presented while in SHIFT and not on the last bit is not accepted. The producer holds load and I until load_ready.
- Word bits are never modified by serial_in. The serial_in bits only occupy positions already shifted out.

## Timing
- Reset (async, immediate): state=IDLE, shreg=0, cnt=0, order=0.
- Output values under reset:
  - serial_out=0
  - serial_valid=0
  - last=0
  - busy=0
  - load_ready=1
- Latency: the first bit appears on serial_out in the cycle after the accepting edge. There is no combinational path from I to serial_out.
- Frame length: exactly WIDTH cycles with shift_en=1. Each cycle with shift_en=0 extends the frame by one.
- Throughput: with load held high and shift_en=1, one word every WIDTH cycles, with serial_valid continuously 1.
- reset_n asserted mid-frame: the frame is abandoned, outputs go to reset values at once, and no partial frame resumes after release.
- lsb_first changing mid-frame has no effect. The order bit is fixed until the next accepted load.
- Simultaneous last && shift_en && load: the next word's first bit follows the final bit on the very next cycle.

## Test plan
- Reset: hold reset_n=0 with load=1 and I=8'hFF, then release. Required: serial_valid=0, load_ready=1, serial_out=0 throughout reset. The load is accepted on the first edge after release.
- MSB-first: WIDTH=8, load I=8'h1E with lsb_first=0, shift_en=1. Required: serial_out = 0,0,0,1,1,1,1,0 on 8 consecutive cycles; last=1 only on the 8th; IDLE afterwards.
- LSB-first and bit-order latch: load 8'h1E with lsb_first=1, then toggle lsb_first mid-frame. Required: serial_out = 0,1,1,1,1,0,0,0.
- Stall: during frame 8'h1E MSB-first, drive shift_en=0 for 3 cycles after bit 4. Required: serial_out holds 1 for 4 cycles total; the frame completes after 11 cycles; load_ready stays 0 during the stall.
- Back-to-back: load held high with 8'h1E then 8'hC3 (MSB-first). Required: 16 contiguous valid bits 0,0,0,1,1,1,1,0,1,1,0,0,0,0,1,1; last pulses on cycles 8 and 16; no serial_valid gap.
- Reset mid-frame: assert reset_n=0 after bit 3 of 8'h1E for 20 ns, then reload 8'hC3. Required: outputs clear immediately and the new frame starts cleanly with 1,1,0,0,0,0,1,1.

Source files
------------

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out serializer. Takes WIDTH-bit words from an upstream
// producer and emits them one bit per enabled clock, in a bit order chosen per
// word at load time. Supports back-to-back frames with no idle bubble.
//
// Handshake: a word is transferred on a rising edge where load && load_ready.
// The producer holds load and I stable until that edge. load_ready is
// combinational from state, cnt and shift_en, so it can rise in the same cycle
// the final bit of the current frame is being consumed.
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   I             parallel word to load
//   load          upstream valid
//   load_ready    block accepts a word this cycle
//   lsb_first     bit order, sampled at acceptance (1 = I[0] first)
//   shift_en      downstream advance; 0 stalls the current bit
//   serial_in     bit shifted into the vacated end (for chaining)
//   serial_out    current serial bit (0 when idle)
//   serial_valid  serial_out carries a frame bit
//   last          serial_out is the final bit of the frame
//   busy          frame in progress
//   state_dbg     FSM state (0 = IDLE, 1 = SHIFT)
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] I,
  input  logic             load,
  output logic             load_ready,
  input  logic             lsb_first,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   shreg;
  logic [CNT_W-1:0]   cnt;
  logic               order;   // latched lsb_first for the frame in flight
  logic               accept;
  logic               advance;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  assign last       = (state_q == SHIFT) && (cnt == '0);
  assign load_ready = (state_q == IDLE) || (last && shift_en);
  assign accept     = load && load_ready;
  // Advance within a frame; the final bit is retired by the state change
  // (or overwritten by a back-to-back load), not by a shift.
  assign advance    = (state_q == SHIFT) && shift_en && (cnt != '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // On the last bit a pending load keeps us in SHIFT with no bubble.
        if (last && shift_en && !load) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, bit counter, order bit
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt   <= '0;
      order <= 1'b0;
    end else if (accept) begin
      shreg <= I;
      cnt   <= CNT_LOAD;
      order <= lsb_first;
    end else if (advance) begin
      // serial_in only fills positions that have already been emitted.
      if (order) begin
        shreg <= {serial_in, shreg[WIDTH-1:1]};
      end else begin
        shreg <= {shreg[WIDTH-2:0], serial_in};
      end
      cnt <= cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    busy         = 1'b0;
    state_dbg    = state_q;
    if (state_q == SHIFT) begin
      serial_valid = 1'b1;
      busy         = 1'b1;
      serial_out   = order ? shreg[0] : shreg[WIDTH-1];
    end
  end

endmodule
